// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel driver: colour widths,
// per-axis mode record, FSM state encoding and the mode consistency test.
`timescale 1ns/1ps
package vga_pkg;

  localparam int BPC = 4;        // bits per colour channel
  localparam int BPP = 3 * BPC;  // bits per pixel
  localparam int CW  = 12;       // counter / mode field width

  // One axis of a video mode; all values are positions on that axis.
  typedef struct packed {
    logic [CW-1:0] width;  // active positions
    logic [CW-1:0] porch;  // position where sync asserts
    logic [CW-1:0] synch;  // position where sync deasserts
    logic [CW-1:0] raw;    // total positions per period
  } vga_mode_t;

  typedef struct packed {
    vga_mode_t h;
    vga_mode_t v;
  } vga_timing_t;

  localparam vga_timing_t MODE_640x480 = '{
    h: '{width: 12'd640, porch: 12'd656, synch: 12'd752, raw: 12'd800},
    v: '{width: 12'd480, porch: 12'd490, synch: 12'd492, raw: 12'd525}
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_ACTIVE = 2'd2
  } vga_state_t;

  // A mode is usable only when active area, sync pulse and total are ordered.
  function automatic logic mode_valid(input vga_mode_t m);
    return (m.width != '0) && (m.width <= m.porch) &&
           (m.porch < m.synch) && (m.synch < m.raw);
  endfunction

endpackage

// File: rtl/vga_pixel_driver_if.sv
// Pixel-source handshake: the driver requests pixels and marks line/frame
// boundaries; the source returns one pixel the cycle after each request.
`timescale 1ns/1ps
interface vga_pixel_driver_if #(
  parameter int BPP = vga_pkg::BPP
) ();

  logic           rd;        // one pixel requested this cycle
  logic           newline;   // last cycle of a line
  logic           newframe;  // last cycle of a frame
  logic [BPP-1:0] pixel;     // returned pixel, valid the cycle after rd

  modport master (output rd, output newline, output newframe, input pixel);
  modport slave  (input rd, input newline, input newframe, output pixel);

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter wrapping at raw-1, plus the wrap,
// sync-window and active-area flags derived from the current position.
`timescale 1ns/1ps
module vga_axis_counter
  import vga_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_reset_n,
  input  logic      i_clr,       // hold position at 0
  input  logic      i_adv,       // step position this cycle
  input  vga_mode_t i_mode,
  output logic      o_wrap,      // position is the last of the period
  output logic      o_sync_act,  // position inside the sync window
  output logic      o_active     // position inside the active area
);

  logic [CW-1:0] r_pos;
  logic          w_wrap;

  assign w_wrap     = (r_pos == (i_mode.raw - 12'd1));
  assign o_wrap     = w_wrap;
  assign o_sync_act = (r_pos >= i_mode.porch) && (r_pos < i_mode.synch);
  assign o_active   = (r_pos < i_mode.width);

  // Position register: explicit compare-based wrap so odd raw values work.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pos <= '0;
    end else if (i_clr) begin
      r_pos <= '0;
    end else if (i_adv) begin
      r_pos <= w_wrap ? '0 : r_pos + 12'd1;
    end
  end

endmodule

// File: rtl/vga_pixel_driver.sv
// VGA raster timing generator and pixel output stage. Requests pixels from a
// source through vga_pixel_driver_if, then registers the returned pixel onto
// the colour pins with hsync/vsync delayed to stay aligned.
// Build option: define VGA_SYNC_POSITIVE_EN for active-high syncs; by default
// syncs are active-low with an idle level of 1.
`timescale 1ns/1ps
module vga_pixel_driver
  import vga_pkg::*;
#(
  parameter int BITS_PER_COLOR = BPC
) (
  input  logic                      i_pixclk,
  input  logic                      i_reset_n,
  input  logic                      i_en,
  input  logic [11:0]               i_hm_width,
  input  logic [11:0]               i_hm_porch,
  input  logic [11:0]               i_hm_synch,
  input  logic [11:0]               i_hm_raw,
  input  logic [11:0]               i_vm_height,
  input  logic [11:0]               i_vm_porch,
  input  logic [11:0]               i_vm_synch,
  input  logic [11:0]               i_vm_raw,
  vga_pixel_driver_if.master        src_if,
  output logic                      o_cfg_err,
  output logic                      o_vga_hsync,
  output logic                      o_vga_vsync,
  output logic [BITS_PER_COLOR-1:0] o_vga_red,
  output logic [BITS_PER_COLOR-1:0] o_vga_green,
  output logic [BITS_PER_COLOR-1:0] o_vga_blue
);

  localparam int PW = 3 * BITS_PER_COLOR;

`ifdef VGA_SYNC_POSITIVE_EN
  localparam logic SYNC_ON = 1'b1;
`else
  localparam logic SYNC_ON = 1'b0;
`endif

  vga_state_t r_state, w_state_next;
  vga_mode_t  r_hmode, r_vmode;
  vga_mode_t  w_in_h, w_in_v;
  logic       r_cfg_err;
  logic       w_in_valid, w_latch, w_frame_end, w_clr;
  logic       w_h_wrap, w_h_sync, w_h_act;
  logic       w_v_wrap, w_v_sync, w_v_act;
  logic       w_rd, w_newline, w_newframe, w_hs, w_vs;
  logic       r_de1, r_hs1, r_vs1;
  logic       r_hsync, r_vsync;
  logic [PW-1:0] r_rgb;

  assign w_in_h     = '{width: i_hm_width,  porch: i_hm_porch, synch: i_hm_synch, raw: i_hm_raw};
  assign w_in_v     = '{width: i_vm_height, porch: i_vm_porch, synch: i_vm_synch, raw: i_vm_raw};
  assign w_in_valid = mode_valid(w_in_h) && mode_valid(w_in_v);
  assign w_clr      = (r_state != ST_ACTIVE);

  vga_axis_counter u_hcnt (
    .i_clk      (i_pixclk),
    .i_reset_n  (i_reset_n),
    .i_clr      (w_clr),
    .i_adv      (1'b1),
    .i_mode     (r_hmode),
    .o_wrap     (w_h_wrap),
    .o_sync_act (w_h_sync),
    .o_active   (w_h_act)
  );

  vga_axis_counter u_vcnt (
    .i_clk      (i_pixclk),
    .i_reset_n  (i_reset_n),
    .i_clr      (w_clr),
    .i_adv      (w_h_wrap),
    .i_mode     (r_vmode),
    .o_wrap     (w_v_wrap),
    .o_sync_act (w_v_sync),
    .o_active   (w_v_act)
  );

  // FSM state register.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, mode-latch strobe and source-facing strobes.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_frame_end  = 1'b0;
    w_rd         = 1'b0;
    w_newline    = 1'b0;
    w_newframe   = 1'b0;
    w_hs         = 1'b0;
    w_vs         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en) begin
          w_latch = 1'b1;
          if (w_in_valid) w_state_next = ST_PRIME;
        end
      end
      ST_PRIME: begin
        // Pulses here let the source rewind to the top of its frame.
        w_newline    = 1'b1;
        w_newframe   = 1'b1;
        w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        w_rd        = w_h_act && w_v_act;
        w_newline   = w_h_wrap;
        w_frame_end = w_h_wrap && w_v_wrap;
        w_newframe  = w_frame_end;
        w_hs        = w_h_sync;
        w_vs        = w_v_sync;
        if (w_frame_end) begin
          w_latch = 1'b1;
          if (!i_en || !w_in_valid) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Mode registers only change between frames; error tracks the last latch.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hmode   <= '0;
      r_vmode   <= '0;
      r_cfg_err <= 1'b0;
    end else if (w_latch) begin
      r_hmode   <= w_in_h;
      r_vmode   <= w_in_v;
      r_cfg_err <= !w_in_valid;
    end
  end

  // Two-stage output pipeline: stage 1 waits for the pixel, stage 2 drives pins.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_de1   <= 1'b0;
      r_hs1   <= 1'b0;
      r_vs1   <= 1'b0;
      r_rgb   <= '0;
      r_hsync <= ~SYNC_ON;
      r_vsync <= ~SYNC_ON;
    end else begin
      r_de1   <= w_rd;
      r_hs1   <= w_hs;
      r_vs1   <= w_vs;
      r_rgb   <= r_de1 ? src_if.pixel : '0;
      r_hsync <= r_hs1 ? SYNC_ON : ~SYNC_ON;
      r_vsync <= r_vs1 ? SYNC_ON : ~SYNC_ON;
    end
  end

  assign src_if.rd       = w_rd;
  assign src_if.newline  = w_newline;
  assign src_if.newframe = w_newframe;

  assign o_cfg_err   = r_cfg_err;
  assign o_vga_hsync = r_hsync;
  assign o_vga_vsync = r_vsync;
  assign o_vga_red   = r_rgb[PW-1 -: BITS_PER_COLOR];
  assign o_vga_green = r_rgb[2*BITS_PER_COLOR-1 -: BITS_PER_COLOR];
  assign o_vga_blue  = r_rgb[BITS_PER_COLOR-1:0];

endmodule

// File: tb/tb_vga_pixel_driver.sv
// Directed bench for vga_pixel_driver: a reference raster model compares the
// full output vector every cycle, plus hand-computed per-line/frame counts.
`timescale 1ns/1ps
module tb_vga_pixel_driver;
  import vga_pkg::*;

`ifdef VGA_SYNC_POSITIVE_EN
  localparam logic ON = 1'b1;
`else
  localparam logic ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic [11:0] hm_width, hm_porch, hm_synch, hm_raw;
  logic [11:0] vm_height, vm_porch, vm_synch, vm_raw;
  logic        cfg_err, hsync, vsync;
  logic [3:0]  red, green, blue;

  vga_pixel_driver_if #(.BPP(BPP)) pix_if ();

  vga_pixel_driver #(.BITS_PER_COLOR(BPC)) dut (
    .i_pixclk    (clk),
    .i_reset_n   (rst_n),
    .i_en        (en),
    .i_hm_width  (hm_width),
    .i_hm_porch  (hm_porch),
    .i_hm_synch  (hm_synch),
    .i_hm_raw    (hm_raw),
    .i_vm_height (vm_height),
    .i_vm_porch  (vm_porch),
    .i_vm_synch  (vm_synch),
    .i_vm_raw    (vm_raw),
    .src_if      (pix_if.master),
    .o_cfg_err   (cfg_err),
    .o_vga_hsync (hsync),
    .o_vga_vsync (vsync),
    .o_vga_red   (red),
    .o_vga_green (green),
    .o_vga_blue  (blue)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side copies of the pins and of the mode the model is rastering.
  int p_w, p_hp, p_hs, p_hr, p_h, p_vp, p_vs, p_vr;
  int m_w, m_hp, m_hs, m_hr, m_h, m_vp, m_vs, m_vr;
  bit m_act, m_err;
  int h, v;
  bit md1, md2, mh1, mh2, mv1, mv2;
  int src_cnt, exp_cnt;
  bit rd_prev;
  int cnt_rd, cnt_hs, cnt_nl, cnt_nf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] dut_vec();
    return {cfg_err, pix_if.rd, pix_if.newline, pix_if.newframe, hsync, vsync, red, green, blue};
  endfunction

  function automatic logic lvl(input bit act);
    return act ? ON : ~ON;
  endfunction

  task automatic set_mode(input int w, hp, hs, hr, vh, vp, vs, vr);
    p_w = w;  p_hp = hp; p_hs = hs; p_hr = hr;
    p_h = vh; p_vp = vp; p_vs = vs; p_vr = vr;
    hm_width  = 12'(w);  hm_porch = 12'(hp); hm_synch = 12'(hs); hm_raw = 12'(hr);
    vm_height = 12'(vh); vm_porch = 12'(vp); vm_synch = 12'(vs); vm_raw = 12'(vr);
  endtask

  // Called at the negedge of the PRIME cycle.
  task automatic start_prime(input string tag);
    check(tag, dut_vec(), {m_err, 1'b0, 1'b1, 1'b1, ~ON, ~ON, 12'h000});
    m_w = p_w; m_hp = p_hp; m_hs = p_hs; m_hr = p_hr;
    m_h = p_h; m_vp = p_vp; m_vs = p_vs; m_vr = p_vr;
    m_act = 1'b1; h = 0; v = 0;
    md1 = 0; md2 = 0; mh1 = 0; mh2 = 0; mv1 = 0; mv2 = 0;
    src_cnt = 0; exp_cnt = 0; rd_prev = 0;
    pix_if.pixel = 12'hF0F;
    @(negedge clk);
  endtask

  // One cycle: compare outputs, feed the source, advance the reference raster.
  task automatic step();
    logic        e_rd, e_nl, e_nf;
    logic [11:0] e_rgb;
    e_rd = m_act && (h < m_w) && (v < m_h);
    e_nl = m_act && (h == m_hr - 1);
    e_nf = e_nl && (v == m_vr - 1);
    if (md2) begin
      e_rgb = 12'(exp_cnt);
      exp_cnt++;
    end else begin
      e_rgb = 12'h000;
    end
    check($sformatf("cyc h%0d v%0d", h, v), dut_vec(),
          {m_err, e_rd, e_nl, e_nf, lvl(mh2), lvl(mv2), e_rgb});
    if (pix_if.rd) cnt_rd++;
    if (hsync == ON) cnt_hs++;
    if (pix_if.newline) cnt_nl++;
    if (pix_if.newframe) cnt_nf++;
    if (rd_prev) begin
      pix_if.pixel = 12'(src_cnt);
      src_cnt++;
    end else begin
      pix_if.pixel = 12'hF0F;
    end
    rd_prev = pix_if.rd;
    md2 = md1; md1 = e_rd;
    mh2 = mh1; mh1 = m_act && (h >= m_hp) && (h < m_hs);
    mv2 = mv1; mv1 = m_act && (v >= m_vp) && (v < m_vs);
    if (m_act) begin
      if (h == m_hr - 1) begin
        h = 0;
        if (v == m_vr - 1) begin
          v = 0;
          m_w = p_w; m_hp = p_hp; m_hs = p_hs; m_hr = p_hr;
          m_h = p_h; m_vp = p_vp; m_vs = p_vs; m_vr = p_vr;
          if (!en) m_act = 1'b0;
        end else begin
          v++;
        end
      end else begin
        h++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_counts();
    cnt_rd = 0; cnt_hs = 0; cnt_nl = 0; cnt_nf = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    m_err = 1'b0;
    m_act = 1'b0;
    pix_if.pixel = 12'h000;
    set_mode(640, 656, 752, 800, 480, 490, 492, 525);
    repeat (3) @(negedge clk);
    $display("phase reset");
    check("rst_vec", dut_vec(), {1'b0, 1'b0, 1'b0, 1'b0, ~ON, ~ON, 12'h000});

    // 640x480 from reset: one line of timing, then a reset mid-line.
    $display("phase 640x480");
    en = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    start_prime("prime_640");
    clr_counts();
    run(800);
    check("rd_per_line_640", cnt_rd, 640);
    check("hs_per_line_640", cnt_hs, 96);
    check("nl_per_line_640", cnt_nl, 1);
    run(400);
    rst_n = 1'b0;
    #1;
    check("rst_midline", dut_vec(), {1'b0, 1'b0, 1'b0, 1'b0, ~ON, ~ON, 12'h000});

    // Small mode A: 8/10/12/14 x 4/5/6/8, 112 clocks per frame.
    $display("phase mode A");
    set_mode(8, 10, 12, 14, 4, 5, 6, 8);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_prime("prime_a");
    clr_counts();
    run(112);
    check("rd_per_frame_a", cnt_rd, 32);
    check("nl_per_frame_a", cnt_nl, 8);
    check("nf_per_frame_a", cnt_nf, 1);
    check("hs_per_frame_a", cnt_hs, 16);

    // Drop enable at line 2: frame must complete, then stay idle.
    $display("phase enable drop");
    clr_counts();
    run(31);
    en = 1'b0;
    run(81 + 10);
    check("rd_after_drop", cnt_rd, 32);
    check("nf_after_drop", cnt_nf, 1);

    // Porch below width: error latched, no requests.
    $display("phase cfg error");
    set_mode(8, 6, 12, 14, 4, 5, 6, 8);
    en = 1'b1;
    @(negedge clk);
    check("cfg_err_set", {31'b0, cfg_err}, 32'd1);
    m_err = 1'b1;
    clr_counts();
    run(6);
    check("rd_in_err", cnt_rd, 0);

    // Boundary mode B (width == porch) clears the error; mid-frame pin
    // changes to mode A take effect only at the frame end.
    $display("phase mode B relatch");
    set_mode(6, 6, 8, 10, 3, 3, 4, 5);
    @(negedge clk);
    m_err = 1'b0;
    start_prime("prime_b");
    clr_counts();
    run(25);
    set_mode(8, 10, 12, 14, 4, 5, 6, 8);
    run(25);
    check("rd_per_frame_b", cnt_rd, 18);
    check("nl_per_frame_b", cnt_nl, 5);
    clr_counts();
    en = 1'b0;
    run(112 + 5);
    check("rd_relatched_a", cnt_rd, 32);
    check("nl_relatched_a", cnt_nl, 8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
